// File: rtl/string_swap_seq.sv
// Byte-serial string reversal with optional NUL compaction.
// Define STRING_SWAP_COMPACT_EN to pack non-NUL bytes toward byte 0.
module string_swap_seq #(
  parameter int LEN = 32,
  parameter int LW  = $clog2(LEN/8+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_data,
  output logic [LW-1:0]  out_len,
  output logic           busy
);

  localparam int N = LEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  logic [LEN-1:0]  r_src;
  logic [LEN-1:0]  r_dst;
  logic [LW-1:0]   r_idx;
  logic [LW-1:0]   r_len;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [7:0]      w_byte;
  logic            w_nz;
  logic            w_wr;
  logic [LW-1:0]   w_ptr;

`ifdef STRING_SWAP_COMPACT_EN
  logic [LW-1:0]   r_wp;
  assign w_ptr = r_wp;
  assign w_wr  = w_nz;
`else
  assign w_ptr = r_idx;
  assign w_wr  = 1'b1;
`endif

  // Source shifts left each cycle, so the next character is always on top.
  assign w_byte = r_src[LEN-1 -: 8];
  assign w_nz   = |w_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef STRING_SWAP_COMPACT_EN
      r_wp        <= '0;
`endif
    end else if (clr) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef STRING_SWAP_COMPACT_EN
      r_wp        <= '0;
`endif
      if (r_busy) begin
        r_dst <= '0;
        r_len <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_src      <= in_data;
            r_dst      <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
`ifdef STRING_SWAP_COMPACT_EN
            r_wp       <= '0;
`endif
          end
        end
        RUN: begin
          r_src <= r_src << 8;
          r_idx <= r_idx + LW'(1);
          if (w_wr) begin
            for (int b = 0; b < N; b++) begin
              if (w_ptr == LW'(b))
                r_dst[b*8 +: 8] <= w_byte;
            end
          end
          if (w_nz) begin
            r_len <= r_len + LW'(1);
`ifdef STRING_SWAP_COMPACT_EN
            r_wp  <= r_wp + LW'(1);
`endif
          end
          if (r_idx == LW'(N-1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_dst;
  assign out_len   = r_len;
  assign busy      = r_busy;

endmodule

// File: tb/tb_string_swap_seq.sv
// Scoreboard bench for string_swap_seq, LEN=32.
module tb_string_swap_seq;

  localparam int LEN = 32;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [LEN-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [LEN-1:0] out_data;
  logic [LW-1:0]  out_len;
  logic           busy;

  typedef struct packed {
    logic [LEN-1:0] d;
    logic [LW-1:0]  l;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  string_swap_seq #(.LEN(LEN), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none",
                 out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_len", 64'(out_len), 64'(e.l));
      end
    end
  end

  task automatic accept(input logic [LEN-1:0] d,
                        input logic [LEN-1:0] ed,
                        input logic [LW-1:0] el,
                        input bit push);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (push) q.push_back('{d: ed, l: el});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_vec(input logic [LEN-1:0] d,
                         input logic [LEN-1:0] ed,
                         input logic [LW-1:0] el);
    int lat;
    accept(d, ed, el, 1'b1);
    wait_out(lat);
    chk("latency", 64'(lat), 64'd4);
    @(posedge clk); #1;
  endtask

  logic [LEN-1:0] e_mix, e_low, e_ends;

  initial begin
    int lat;
`ifdef STRING_SWAP_COMPACT_EN
    e_mix  = 32'h0000_4341;
    e_low  = 32'h0000_0041;
    e_ends = 32'h0000_3412;
`else
    e_mix  = 32'h0043_0041;
    e_low  = 32'h4100_0000;
    e_ends = 32'h3400_0012;
`endif
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_len", 64'(out_len), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_vec(32'h4142_4344, 32'h4443_4241, 3'd4);
    run_vec(32'h4100_4300, e_mix, 3'd2);
    run_vec(32'h0000_0000, 32'h0000_0000, 3'd0);
    run_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4);
    run_vec(32'h0000_0041, e_low, 3'd1);
    run_vec(32'h1200_0034, e_ends, 3'd2);

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    accept(32'h4142_4344, 32'h4443_4241, 3'd4, 1'b1);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    wait_out(lat);
    chk("hold_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'h4443_4241);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", 64'(out_valid), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("keep_data", 64'(out_data), 64'h4443_4241);
    chk("keep_len", 64'(out_len), 64'd4);

    // Abort while index 2 is being processed.
    accept(32'h4142_4344, '0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("clr_no_valid", 64'(out_valid), 64'd0);
    end
    run_vec(32'h1200_0034, e_ends, 3'd2);

    // Asynchronous reset in the middle of RUN.
    accept(32'h4142_4344, '0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_len", 64'(out_len), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    run_vec(32'h4100_4300, e_mix, 3'd2);

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
